// File: rtl/uart_mmio_port_pkg.sv
// Shared definitions for the memory-mapped UART: register indices, STATUS bit
// positions, FSM state encodings and the effective-divisor helper.
package uart_mmio_port_pkg;

   localparam logic [31:0] UART_TXDATA  = 32'd0;
   localparam logic [31:0] UART_STATUS  = 32'd1;
   localparam logic [31:0] UART_RXDATA  = 32'd2;
   localparam logic [31:0] UART_BAUDDIV = 32'd3;

   localparam int ST_TX_BUSY    = 0;
   localparam int ST_RX_VALID   = 1;
   localparam int ST_RX_OVERRUN = 2;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   // The stored divisor is kept as written; only its use is floored.
   function automatic logic [15:0] eff_div(input logic [15:0] div, input logic [15:0] floor_val);
      return (div < floor_val) ? floor_val : div;
   endfunction

endpackage

// File: rtl/uart_mmio_port_rx_core.sv
// UART receive path: 2-flop synchroniser, start-edge detect, half-bit start
// validation, 8 LSB-first data samples and a stop-bit check.
module uart_mmio_port_rx_core
   import uart_mmio_port_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_rx,
   input  logic [15:0] i_div_eff,
   output logic [7:0]  o_rx_byte,
   output logic        o_rx_done
);

   logic        r_sync1;
   logic        r_sync2;
   logic        r_sync_prev;
   rx_state_t   r_state;
   logic [15:0] r_div;
   logic [15:0] r_cnt;
   logic [3:0]  r_bit;
   logic [7:0]  r_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_sync_prev <= 1'b1;
         r_state     <= RX_IDLE;
         r_div       <= '0;
         r_cnt       <= '0;
         r_bit       <= '0;
         r_shift     <= '0;
         o_rx_byte   <= '0;
         o_rx_done   <= 1'b0;
      end else begin
         r_sync1     <= i_rx;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
         o_rx_done   <= 1'b0;
         unique case (r_state)
            RX_IDLE: begin
               if (r_sync_prev && !r_sync2) begin
                  r_div   <= i_div_eff;
                  r_cnt   <= i_div_eff >> 1;
                  r_state <= RX_START;
               end
            end
            RX_START: begin
               // A line back high at mid start bit was only a glitch.
               if (r_cnt == 16'd0) begin
                  if (r_sync2) begin
                     r_state <= RX_IDLE;
                  end else begin
                     r_cnt   <= r_div;
                     r_bit   <= '0;
                     r_state <= RX_DATA;
                  end
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            RX_DATA: begin
               if (r_cnt == 16'd0) begin
                  r_shift <= {r_sync2, r_shift[7:1]};
                  r_cnt   <= r_div;
                  if (r_bit == 4'd7) begin
                     r_state <= RX_STOP;
                  end else begin
                     r_bit <= r_bit + 4'd1;
                  end
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            RX_STOP: begin
               if (r_cnt == 16'd0) begin
                  r_state <= RX_IDLE;
                  if (r_sync2) begin
                     o_rx_byte <= r_shift;
                     o_rx_done <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt - 16'd1;
               end
            end
            default: r_state <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_mmio_port.sv
// Memory-mapped 8N1 UART on the data bus: register file, TX serialiser and the
// rx_valid / rx_overrun flag logic around the receive core.
module uart_mmio_port
   import uart_mmio_port_pkg::*;
#(
   parameter logic [15:0] DIV_RESET = 16'd433,
   parameter logic [15:0] DIV_MIN   = 16'd3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Select,
   input  logic        Write,
   input  logic [31:0] Addr,
   input  logic [31:0] DataIn,
   output logic [31:0] DataOut,
   output logic        tx,
   input  logic        rx
);

   logic        w_wr;
   logic        w_wr_tx;
   logic        w_wr_status;
   logic        w_wr_baud;
   logic [15:0] w_div_eff;
   logic        w_tx_busy;
   logic [7:0]  w_rx_byte;
   logic        w_rx_done;
   logic        w_unused;

   tx_state_t   r_tx_state;
   logic        r_tx;
   logic [7:0]  r_txdata;
   logic [7:0]  r_tx_shift;
   logic [15:0] r_tx_div;
   logic [15:0] r_tx_cnt;
   logic [3:0]  r_tx_bit;

   logic [15:0] r_bauddiv;
   logic [7:0]  r_rxdata;
   logic        r_rx_valid;
   logic        r_rx_overrun;

   assign w_wr        = Select && Write;
   assign w_wr_tx     = w_wr && (Addr == UART_TXDATA);
   assign w_wr_status = w_wr && (Addr == UART_STATUS);
   assign w_wr_baud   = w_wr && (Addr == UART_BAUDDIV);
   assign w_div_eff   = eff_div(r_bauddiv, DIV_MIN);
   assign w_tx_busy   = (r_tx_state != TX_IDLE);
   assign tx          = r_tx;
   assign w_unused    = ^DataIn[31:16];

   // Writes to TXDATA are only honoured from IDLE, so a busy-time write
   // leaves the holding register and the frame in flight untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx_state <= TX_IDLE;
         r_tx       <= 1'b1;
         r_txdata   <= '0;
         r_tx_shift <= '0;
         r_tx_div   <= '0;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
      end else begin
         unique case (r_tx_state)
            TX_IDLE: begin
               if (w_wr_tx) begin
                  r_txdata   <= DataIn[7:0];
                  r_tx_shift <= DataIn[7:0];
                  r_tx       <= 1'b0;
                  r_tx_div   <= w_div_eff;
                  r_tx_cnt   <= '0;
                  r_tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (r_tx_cnt == r_tx_div) begin
                  r_tx_cnt   <= '0;
                  r_tx       <= r_tx_shift[0];
                  r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                  r_tx_bit   <= '0;
                  r_tx_state <= TX_DATA;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            TX_DATA: begin
               if (r_tx_cnt == r_tx_div) begin
                  r_tx_cnt <= '0;
                  if (r_tx_bit == 4'd7) begin
                     r_tx       <= 1'b1;
                     r_tx_state <= TX_STOP;
                  end else begin
                     r_tx       <= r_tx_shift[0];
                     r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                     r_tx_bit   <= r_tx_bit + 4'd1;
                  end
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            TX_STOP: begin
               if (r_tx_cnt == r_tx_div) begin
                  r_tx_cnt   <= '0;
                  r_tx_state <= TX_IDLE;
               end else begin
                  r_tx_cnt <= r_tx_cnt + 16'd1;
               end
            end
            default: r_tx_state <= TX_IDLE;
         endcase
      end
   end

   // Hardware sets are applied after software clears so that a set wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bauddiv    <= DIV_RESET;
         r_rxdata     <= '0;
         r_rx_valid   <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         if (w_wr_baud) begin
            r_bauddiv <= DataIn[15:0];
         end
         if (w_wr_status && DataIn[ST_RX_VALID]) begin
            r_rx_valid <= 1'b0;
         end
         if (w_wr_status && DataIn[ST_RX_OVERRUN]) begin
            r_rx_overrun <= 1'b0;
         end
         if (w_rx_done) begin
            if (!r_rx_valid) begin
               r_rxdata   <= w_rx_byte;
               r_rx_valid <= 1'b1;
            end else begin
               r_rx_overrun <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      DataOut = '0;
      if (Select) begin
         case (Addr)
            UART_TXDATA:  DataOut[7:0]  = r_txdata;
            UART_STATUS: begin
               DataOut[ST_TX_BUSY]    = w_tx_busy;
               DataOut[ST_RX_VALID]   = r_rx_valid;
               DataOut[ST_RX_OVERRUN] = r_rx_overrun;
            end
            UART_RXDATA:  DataOut[7:0]  = r_rxdata;
            UART_BAUDDIV: DataOut[15:0] = r_bauddiv;
            default:      DataOut       = '0;
         endcase
      end
   end

   uart_mmio_port_rx_core u_rx_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rx      (rx),
      .i_div_eff (w_div_eff),
      .o_rx_byte (w_rx_byte),
      .o_rx_done (w_rx_done)
   );

endmodule
